// File: rtl/daq_channel_packer_pkg.sv
// Shared encodings and field positions for the DAQ channel packer.
package daq_pkg;

   // Samples per packed word; the reserved code behaves like PACK_1.
   typedef enum logic [1:0] {
      PACK_1    = 2'd0,
      PACK_2    = 2'd1,
      PACK_4    = 2'd2,
      PACK_RSVD = 2'd3
   } pack_mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // control word fields
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_OVF_CLR = 3;
   localparam int CTRL_WM_LO   = 8;

   // status word fields (count occupies [aw:0])
   localparam int STAT_EMPTY   = 16;
   localparam int STAT_FULL    = 17;
   localparam int STAT_OVF     = 18;
   localparam int STAT_BUSY    = 19;
   localparam int STAT_MODE_LO = 20;
   localparam int STAT_DROP_LO = 24;

   function automatic pack_mode_t eff_mode(input logic [1:0] raw);
      return (raw == 2'd3) ? PACK_1 : pack_mode_t'(raw);
   endfunction

endpackage

// File: rtl/daq_channel_packer_if.sv
// Burst handshake toward the SRAM write state machine.
interface daq_channel_packer_if #(
   parameter int dw = 32
);
   logic [dw-1:0] data_out;
   logic          data_valid;
   logic          sram_ready;
   logic          start_sram;

   modport master (output data_out, data_valid, start_sram, input sram_ready);
   modport slave  (input data_out, data_valid, start_sram, output sram_ready);
endinterface

// File: rtl/daq_channel_packer_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module daq_sync_fifo #(
   parameter int dw    = 32,
   parameter int depth = 16,
   localparam int aw   = $clog2(depth)
) (
   input  logic          i_clk,
   input  logic          i_srst,
   input  logic          i_push,
   input  logic [dw-1:0] i_data,
   input  logic          i_pop,
   output logic [dw-1:0] o_data,
   output logic          o_push_ok,
   output logic [aw:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);
   logic [dw-1:0] r_mem [depth];
   logic [aw-1:0] r_wr_ptr;
   logic [aw-1:0] r_rd_ptr;
   logic [aw:0]   r_count;
   logic          w_pop_ok;
   logic          w_push_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (aw+1)'(depth));
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_push_ok = w_push_ok;
   assign o_count   = r_count;
   // Head word is presented directly; forced to zero when nothing is stored.
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally at depth (power of two); count tracks fill.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
         else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
      end
   end
endmodule

// File: rtl/daq_channel_packer.sv
// DAQ channel packer: packs ADC samples into words, buffers them and
// bursts watermark-sized blocks to the SRAM writer.
module daq_channel_packer
   import daq_pkg::*;
#(
   parameter int dw     = 32,
   parameter int adc_dw = 8,
   parameter int depth  = 16,
   localparam int aw    = $clog2(depth)
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              master_enable,
   input  logic [dw-1:0]     control,
   input  logic [adc_dw-1:0] adc_data,
   input  logic              adc_valid,
   output logic [dw-1:0]     status,
   daq_channel_packer_if.master sram_if
);
   logic          w_en;
   pack_mode_t    w_mode;
   pack_mode_t    r_mode_prev;
   logic          w_mode_chg;
   logic [1:0]    r_lane;
   logic [1:0]    w_lane_base;
   logic [1:0]    w_lane_last;
   int            w_shift;
   logic [dw-1:0] r_word;
   logic [dw-1:0] w_word_base;
   logic [dw-1:0] w_word_ins;
   logic          r_push_valid;
   logic [dw-1:0] r_push_word;
   logic          w_push_ok;
   logic          w_drop;
   logic [dw-1:0] w_fifo_data;
   logic [aw:0]   w_count;
   logic          w_full;
   logic          w_empty;
   logic          r_overflow;
   logic [7:0]    r_drop_cnt;
   logic [7:0]    w_wm_raw;
   logic [aw:0]   w_wm;
   state_t        r_state;
   state_t        w_state_next;
   logic [aw:0]   r_burst_len;
   logic [aw:0]   w_burst_len_next;
   logic          r_start_sram;
   logic          w_start_next;
   logic          w_data_valid;
   logic          w_pop;
   logic [dw-1:0] w_status;
   logic [dw-1:0] r_status;
   logic          w_unused_ctrl;

   assign w_en          = master_enable & control[CTRL_EN];
   assign w_mode        = eff_mode(control[CTRL_MODE_LO +: 2]);
   assign w_mode_chg    = (w_mode != r_mode_prev);
   assign w_wm_raw      = control[CTRL_WM_LO +: 8];
   assign w_unused_ctrl = ^{control[dw-1:16], control[7:4]};

   // A mode change abandons any partial word: restart from lane 0.
   assign w_lane_base = w_mode_chg ? 2'd0 : r_lane;
   assign w_word_base = w_mode_chg ? '0 : r_word;

   // Last lane index and bit offset of the current lane for the active mode.
   always_comb begin
      w_lane_last = 2'd0;
      w_shift     = 0;
      case (w_mode)
         PACK_2: begin
            w_lane_last = 2'd1;
            w_shift     = int'(w_lane_base) * (dw / 2);
         end
         PACK_4: begin
            w_lane_last = 2'd3;
            w_shift     = int'(w_lane_base) * (dw / 4);
         end
         default: ;
      endcase
      w_word_ins = w_word_base | ({{(dw-adc_dw){1'b0}}, adc_data} << w_shift);
   end

   // Lane accumulation; a completed word is staged for push on the next edge.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_mode_prev  <= PACK_1;
         r_lane       <= 2'd0;
         r_word       <= '0;
         r_push_valid <= 1'b0;
         r_push_word  <= '0;
      end else begin
         r_mode_prev  <= w_mode;
         r_push_valid <= 1'b0;
         if (!w_en) begin
            r_lane <= 2'd0;
            r_word <= '0;
         end else if (adc_valid) begin
            if (w_lane_base == w_lane_last) begin
               r_push_valid <= 1'b1;
               r_push_word  <= w_word_ins;
               r_lane       <= 2'd0;
               r_word       <= '0;
            end else begin
               r_lane <= w_lane_base + 2'd1;
               r_word <= w_word_ins;
            end
         end else begin
            r_lane <= w_lane_base;
            r_word <= w_word_base;
         end
      end
   end

   daq_sync_fifo #(.dw(dw), .depth(depth)) u_fifo (
      .i_clk     (wb_clk),
      .i_srst    (wb_rst),
      .i_push    (r_push_valid),
      .i_data    (r_push_word),
      .i_pop     (w_pop),
      .o_data    (w_fifo_data),
      .o_push_ok (w_push_ok),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign w_drop = r_push_valid && !w_push_ok;

   // Sticky overflow and saturating drop counter; clear has priority.
   always_ff @(posedge wb_clk) begin
      if (wb_rst || control[CTRL_OVF_CLR]) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   // Watermark: zero means one word, anything above depth means depth.
   always_comb begin
      if (w_wm_raw == 8'd0)            w_wm = (aw+1)'(1);
      else if (int'(w_wm_raw) > depth) w_wm = (aw+1)'(depth);
      else                             w_wm = (aw+1)'(w_wm_raw);
   end

   // Burst FSM next state, pop decision and data_valid.
   always_comb begin
      w_state_next     = r_state;
      w_burst_len_next = r_burst_len;
      w_start_next     = 1'b0;
      w_data_valid     = 1'b0;
      w_pop            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_en && (w_count >= w_wm)) begin
               w_burst_len_next = w_wm;
               w_start_next     = 1'b1;
               w_state_next     = ST_BURST;
            end
         end
         ST_BURST: begin
            w_data_valid = !w_empty;
            w_pop        = w_data_valid && sram_if.sram_ready;
            if (w_pop) begin
               w_burst_len_next = r_burst_len - 1'b1;
               if (r_burst_len == (aw+1)'(1)) w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM state, remaining burst length and start pulse registers.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_state      <= ST_IDLE;
         r_burst_len  <= '0;
         r_start_sram <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_burst_len  <= w_burst_len_next;
         r_start_sram <= w_start_next;
      end
   end

   // Status word assembly from current internal state.
   always_comb begin
      w_status                        = '0;
      w_status[aw:0]                  = w_count;
      w_status[STAT_EMPTY]            = w_empty;
      w_status[STAT_FULL]             = w_full;
      w_status[STAT_OVF]              = r_overflow;
      w_status[STAT_BUSY]             = (r_state == ST_BURST);
      w_status[STAT_MODE_LO +: 2]     = w_mode;
      w_status[STAT_DROP_LO +: 8]     = r_drop_cnt;
   end

   // Registered status, one cycle behind the internal state.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) r_status <= '0;
      else        r_status <= w_status;
   end

   assign status             = r_status;
   assign sram_if.data_out   = w_fifo_data;
   assign sram_if.data_valid = w_data_valid;
   assign sram_if.start_sram = r_start_sram;
endmodule
